// File: rtl/adc_pkg.sv
// Shared capture-controller types and default sizing for the ADC burst capture path.
// No logic here; imported by adc_capture_ctrl and adc_trig_detect.
package adc_pkg;

  localparam int ADC_DATA_W        = 10;
  localparam int ADC_ADDR_W        = 10;
  localparam int ADC_DECIM_W       = 8;
  localparam int ADC_SETTLE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    WAIT_TRIG = 2'd2,
    CAPTURE   = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Rising-level trigger: fires on a valid sample crossing up through level; combinational hit, 1-cycle prev history.
// No backpressure; clear drops the history so the first sample after it can never fire.
module adc_trig_detect
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
)(
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] level,
  output logic              trig_hit
);

  logic [DATA_W-1:0] prev_dat;
  logic              prev_vld;

  always_ff @(posedge sys_clk) begin
    if (!reset_n || clear) begin
      prev_dat <= '0;
      prev_vld <= 1'b0;
    end else if (sample_vld) begin
      prev_dat <= sample;
      prev_vld <= 1'b1;
    end
  end

  assign trig_hit = sample_vld && prev_vld && (prev_dat < level) && (sample >= level);

endmodule

// File: rtl/adc_capture_ctrl.sv
// One-shot burst capture of decimated ADC samples into a sample RAM; buffer write lands 1 cycle after the valid sample.
// No backpressure: samples arriving while not capturing (or dropped by decimation) are discarded.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W        = ADC_DATA_W,
  parameter int ADDR_W        = ADC_ADDR_W,
  parameter int DECIM_W       = ADC_DECIM_W,
  parameter int SETTLE_CYCLES = ADC_SETTLE_CYCLES
)(
  input  logic               SYS_CLK,
  input  logic               RESET_N,
  input  logic               CFG_START,
  input  logic               CFG_ABORT,
  input  logic [ADDR_W:0]    CFG_LEN,
  input  logic [DECIM_W-1:0] CFG_DECIM,
  input  logic               CFG_TRIG_EN,
  input  logic [DATA_W-1:0]  CFG_TRIG_LEVEL,
  input  logic               ADC_LOCKED,
  input  logic [DATA_W-1:0]  APP_DATA,
  input  logic               APP_DATA_VALID,
  output logic               BUF_WE,
  output logic [ADDR_W-1:0]  BUF_ADDR,
  output logic [DATA_W-1:0]  BUF_WDATA,
  output logic               BUSY,
  output logic               DONE,
  output logic               ABORTED,
  output logic               LOCK_ERR,
  output logic [ADDR_W:0]    SAMPLE_COUNT
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  cap_state_e         state, state_nxt;
  logic [ADDR_W:0]    len_q;
  logic [DECIM_W-1:0] decim_q;
  logic               trig_en_q;
  logic [DATA_W-1:0]  level_q;
  logic [SET_W-1:0]   settle_cnt;
  logic [DECIM_W-1:0] decim_cnt;
  logic [ADDR_W:0]    sample_cnt;

  logic keep, last_keep, abort_now, lock_fail, settle_done, decim_adv, start_ok, done_nxt;
  logic trig_hit;

  adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .sys_clk    (SYS_CLK),
    .reset_n    (RESET_N),
    .clear      (state != WAIT_TRIG),
    .sample     (APP_DATA),
    .sample_vld (APP_DATA_VALID),
    .level      (level_q),
    .trig_hit   (trig_hit)
  );

  always_comb begin
    state_nxt   = state;
    keep        = 1'b0;
    abort_now   = 1'b0;
    lock_fail   = 1'b0;
    settle_done = 1'b0;
    decim_adv   = 1'b0;
    start_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (CFG_START) begin
          start_ok = 1'b1;
          if (CFG_LEN != '0) state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (CFG_ABORT) begin
          abort_now = 1'b1;
          state_nxt = IDLE;
        end else if (ADC_LOCKED && settle_cnt == SETTLE_LAST) begin
          settle_done = 1'b1;
          state_nxt   = trig_en_q ? WAIT_TRIG : CAPTURE;
        end
      end
      WAIT_TRIG: begin
        if (CFG_ABORT || !ADC_LOCKED) begin
          abort_now = 1'b1;
          lock_fail = !ADC_LOCKED;
          state_nxt = IDLE;
        end else if (trig_hit) begin
          keep      = 1'b1;
          decim_adv = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (CFG_ABORT || !ADC_LOCKED) begin
          abort_now = 1'b1;
          lock_fail = !ADC_LOCKED;
          state_nxt = IDLE;
        end else if (APP_DATA_VALID) begin
          decim_adv = 1'b1;
          keep      = (decim_cnt == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Final kept sample ends the burst in the same cycle its write is registered.
    last_keep = keep && ((sample_cnt + (ADDR_W+1)'(1)) == len_q);
    if (last_keep) state_nxt = IDLE;
    done_nxt = last_keep || (start_ok && CFG_LEN == '0);
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      len_q      <= '0;
      decim_q    <= '0;
      trig_en_q  <= 1'b0;
      level_q    <= '0;
      settle_cnt <= '0;
      decim_cnt  <= '0;
      sample_cnt <= '0;
      BUF_WE     <= 1'b0;
      BUF_ADDR   <= '0;
      BUF_WDATA  <= '0;
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
      LOCK_ERR   <= 1'b0;
    end else begin
      state   <= state_nxt;
      BUF_WE  <= keep;
      DONE    <= done_nxt;
      ABORTED <= abort_now;
      if (start_ok) begin
        len_q      <= CFG_LEN;
        decim_q    <= CFG_DECIM;
        trig_en_q  <= CFG_TRIG_EN;
        level_q    <= CFG_TRIG_LEVEL;
        sample_cnt <= '0;
        settle_cnt <= '0;
        LOCK_ERR   <= 1'b0;
      end else if (state == SETTLE) begin
        settle_cnt <= ADC_LOCKED ? settle_cnt + SET_W'(1) : '0;
      end
      if (lock_fail) LOCK_ERR <= 1'b1;
      if (settle_done) begin
        decim_cnt <= '0;
      end else if (decim_adv) begin
        decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + DECIM_W'(1);
      end
      if (keep) begin
        BUF_ADDR   <= sample_cnt[ADDR_W-1:0];
        BUF_WDATA  <= APP_DATA;
        sample_cnt <= sample_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  assign BUSY         = (state != IDLE);
  assign SAMPLE_COUNT = sample_cnt;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: settle timing, decimation, trigger, abort, lock loss, reset, full-depth burst.
module tb_adc_capture_ctrl;

  logic        SYS_CLK = 1'b0;
  logic        RESET_N;
  logic        CFG_START, CFG_ABORT, CFG_TRIG_EN;
  logic [10:0] CFG_LEN;
  logic [7:0]  CFG_DECIM;
  logic [9:0]  CFG_TRIG_LEVEL;
  logic        ADC_LOCKED;
  logic [9:0]  APP_DATA;
  logic        APP_DATA_VALID;
  logic        BUF_WE, BUSY, DONE, ABORTED, LOCK_ERR;
  logic [9:0]  BUF_ADDR, BUF_WDATA;
  logic [10:0] SAMPLE_COUNT;

  int total = 0;
  int bad   = 0;

  adc_capture_ctrl dut (
    .SYS_CLK(SYS_CLK), .RESET_N(RESET_N), .CFG_START(CFG_START), .CFG_ABORT(CFG_ABORT),
    .CFG_LEN(CFG_LEN), .CFG_DECIM(CFG_DECIM), .CFG_TRIG_EN(CFG_TRIG_EN),
    .CFG_TRIG_LEVEL(CFG_TRIG_LEVEL), .ADC_LOCKED(ADC_LOCKED), .APP_DATA(APP_DATA),
    .APP_DATA_VALID(APP_DATA_VALID), .BUF_WE(BUF_WE), .BUF_ADDR(BUF_ADDR),
    .BUF_WDATA(BUF_WDATA), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED),
    .LOCK_ERR(LOCK_ERR), .SAMPLE_COUNT(SAMPLE_COUNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic start_cap(input int len, input int decim, input bit trig_en, input int level);
    CFG_LEN        = 11'(len);
    CFG_DECIM      = 8'(decim);
    CFG_TRIG_EN    = trig_en;
    CFG_TRIG_LEVEL = 10'(level);
    CFG_START      = 1'b1;
    tick();
    CFG_START      = 1'b0;
  endtask

  task automatic settle();
    ADC_LOCKED = 1'b1;
    repeat (16) tick();
  endtask

  task automatic sample(input logic [9:0] d);
    APP_DATA       = d;
    APP_DATA_VALID = 1'b1;
    tick();
    APP_DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    total++;
    if ({BUF_WE, BUF_ADDR, BUF_WDATA, BUSY, DONE, ABORTED, LOCK_ERR, SAMPLE_COUNT} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%0b addr=%0h wd=%0h busy=%0b done=%0b ab=%0b lerr=%0b cnt=%0d exp all 0",
               BUF_WE, BUF_ADDR, BUF_WDATA, BUSY, DONE, ABORTED, LOCK_ERR, SAMPLE_COUNT);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int wr_early = 0;
    start_cap(4, 0, 1'b0, 0);
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start got=%0b exp=1", BUSY); end
    // Junk valid samples during settle must never reach the buffer.
    ADC_LOCKED = 1'b1;
    APP_DATA = 10'h3ff;
    APP_DATA_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (BUF_WE !== 1'b0) wr_early++;
    end
    APP_DATA_VALID = 1'b0;
    total++;
    if (wr_early != 0) begin bad++; $display("FAIL basic_settle_writes got=%0d exp=0", wr_early); end
    for (int i = 1; i <= 5; i++) begin
      sample(10'(i));
      total++;
      if (i <= 4) begin
        if ({BUF_WE, BUF_ADDR, BUF_WDATA, DONE, BUSY} !== {1'b1, 10'(i-1), 10'(i), (i == 4), (i != 4)}) begin
          bad++;
          $display("FAIL basic_write%0d got we=%0b addr=%0d wd=%0d done=%0b busy=%0b exp we=1 addr=%0d wd=%0d done=%0b busy=%0b",
                   i, BUF_WE, BUF_ADDR, BUF_WDATA, DONE, BUSY, i-1, i, (i == 4), (i != 4));
        end
      end else if ({BUF_WE, DONE, SAMPLE_COUNT} !== {1'b0, 1'b0, 11'd4}) begin
        bad++;
        $display("FAIL basic_after got we=%0b done=%0b cnt=%0d exp we=0 done=0 cnt=4", BUF_WE, DONE, SAMPLE_COUNT);
      end
    end
  endtask

  task automatic test_decim();
    int done_cnt = 0;
    int widx = 0;
    start_cap(3, 2, 1'b0, 0);
    settle();
    for (int d = 10; d <= 18; d++) begin
      logic exp_we;
      exp_we = (d == 10 || d == 13 || d == 16);
      sample(10'(d));
      if (DONE === 1'b1) done_cnt++;
      total++;
      if (BUF_WE !== exp_we || (exp_we && (BUF_ADDR !== 10'(widx) || BUF_WDATA !== 10'(d)))) begin
        bad++;
        $display("FAIL decim_d%0d got we=%0b addr=%0d wd=%0d exp we=%0b addr=%0d wd=%0d",
                 d, BUF_WE, BUF_ADDR, BUF_WDATA, exp_we, widx, d);
      end
      if (exp_we) widx++;
    end
    total++;
    if (done_cnt != 1 || SAMPLE_COUNT !== 11'd3) begin
      bad++;
      $display("FAIL decim_done got done_pulses=%0d cnt=%0d exp 1 and 3", done_cnt, SAMPLE_COUNT);
    end
  endtask

  task automatic test_trigger();
    logic [9:0] dv  [5] = '{10'd50, 10'd90, 10'd120, 10'd130, 10'd80};
    logic       ew  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [9:0] ea  [5] = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd0};
    logic [9:0] dv2 [4] = '{10'd120, 10'd130, 10'd50, 10'd110};
    start_cap(2, 0, 1'b1, 100);
    settle();
    for (int i = 0; i < 5; i++) begin
      sample(dv[i]);
      total++;
      if (BUF_WE !== ew[i] || (ew[i] && (BUF_ADDR !== ea[i] || BUF_WDATA !== dv[i])) || DONE !== (i == 3)) begin
        bad++;
        $display("FAIL trig_s%0d got we=%0b addr=%0d wd=%0d done=%0b exp we=%0b addr=%0d wd=%0d done=%0b",
                 i, BUF_WE, BUF_ADDR, BUF_WDATA, DONE, ew[i], ea[i], dv[i], (i == 3));
      end
    end
    // First sample above level has no history and must not fire; 130 after 120 is no crossing.
    start_cap(1, 0, 1'b1, 100);
    settle();
    for (int i = 0; i < 4; i++) begin
      sample(dv2[i]);
      total++;
      if (BUF_WE !== (i == 3) || DONE !== (i == 3) || ((i == 3) && (BUF_WDATA !== 10'd110 || BUF_ADDR !== 10'd0))) begin
        bad++;
        $display("FAIL trig_first_s%0d got we=%0b done=%0b addr=%0d wd=%0d exp we=%0b done=%0b addr=0 wd=110",
                 i, BUF_WE, DONE, BUF_ADDR, BUF_WDATA, (i == 3), (i == 3));
      end
    end
  endtask

  task automatic test_settle_restart();
    int wr_early = 0;
    start_cap(1, 0, 1'b0, 0);
    ADC_LOCKED = 1'b1;
    repeat (10) tick();
    ADC_LOCKED = 1'b0;
    tick();
    total++;
    if ({BUSY, ABORTED, LOCK_ERR} !== 3'b100) begin
      bad++;
      $display("FAIL settle_unlock got busy=%0b ab=%0b lerr=%0b exp busy=1 ab=0 lerr=0", BUSY, ABORTED, LOCK_ERR);
    end
    ADC_LOCKED = 1'b1;
    APP_DATA = 10'h3ff;
    APP_DATA_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (BUF_WE !== 1'b0) wr_early++;
    end
    APP_DATA_VALID = 1'b0;
    sample(10'd7);
    total++;
    if (wr_early != 0 || {BUF_WE, DONE, BUF_WDATA} !== {1'b1, 1'b1, 10'd7}) begin
      bad++;
      $display("FAIL settle_restart got early=%0d we=%0b done=%0b wd=%0d exp early=0 we=1 done=1 wd=7",
               wr_early, BUF_WE, DONE, BUF_WDATA);
    end
  endtask

  task automatic test_lock_loss();
    start_cap(8, 0, 1'b0, 0);
    settle();
    sample(10'd1);
    sample(10'd2);
    total++;
    if ({BUF_WE, BUF_ADDR, SAMPLE_COUNT} !== {1'b1, 10'd1, 11'd2}) begin
      bad++;
      $display("FAIL lock_pre got we=%0b addr=%0d cnt=%0d exp we=1 addr=1 cnt=2", BUF_WE, BUF_ADDR, SAMPLE_COUNT);
    end
    ADC_LOCKED = 1'b0;
    sample(10'd3);
    total++;
    if ({BUF_WE, ABORTED, LOCK_ERR, DONE, BUSY, SAMPLE_COUNT} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2}) begin
      bad++;
      $display("FAIL lock_loss got we=%0b ab=%0b lerr=%0b done=%0b busy=%0b cnt=%0d exp we=0 ab=1 lerr=1 done=0 busy=0 cnt=2",
               BUF_WE, ABORTED, LOCK_ERR, DONE, BUSY, SAMPLE_COUNT);
    end
    ADC_LOCKED = 1'b1;
    tick();
    total++;
    if ({ABORTED, LOCK_ERR} !== 2'b01) begin
      bad++;
      $display("FAIL lock_sticky got ab=%0b lerr=%0b exp ab=0 lerr=1", ABORTED, LOCK_ERR);
    end
    // Zero-length start: clears LOCK_ERR and count, DONE one cycle later, never leaves IDLE.
    start_cap(0, 0, 1'b0, 0);
    total++;
    if ({DONE, LOCK_ERR, BUF_WE, BUSY, SAMPLE_COUNT} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
      bad++;
      $display("FAIL len0 got done=%0b lerr=%0b we=%0b busy=%0b cnt=%0d exp done=1 lerr=0 we=0 busy=0 cnt=0",
               DONE, LOCK_ERR, BUF_WE, BUSY, SAMPLE_COUNT);
    end
    tick();
    total++;
    if ({DONE, BUF_WE, BUSY} !== 3'b000) begin
      bad++;
      $display("FAIL len0_after got done=%0b we=%0b busy=%0b exp 0 0 0", DONE, BUF_WE, BUSY);
    end
  endtask

  task automatic test_abort();
    start_cap(3, 0, 1'b0, 0);
    settle();
    sample(10'd1);
    CFG_LEN   = 11'd5;
    CFG_START = 1'b1;
    sample(10'd2);
    CFG_START = 1'b0;
    total++;
    if ({BUF_WE, BUF_ADDR, SAMPLE_COUNT, BUSY} !== {1'b1, 10'd1, 11'd2, 1'b1}) begin
      bad++;
      $display("FAIL abort_busy_start got we=%0b addr=%0d cnt=%0d busy=%0b exp we=1 addr=1 cnt=2 busy=1",
               BUF_WE, BUF_ADDR, SAMPLE_COUNT, BUSY);
    end
    CFG_ABORT = 1'b1;
    sample(10'd3);
    CFG_ABORT = 1'b0;
    total++;
    if ({BUF_WE, ABORTED, DONE, BUSY, SAMPLE_COUNT, LOCK_ERR} !== {1'b0, 1'b1, 1'b0, 1'b0, 11'd2, 1'b0}) begin
      bad++;
      $display("FAIL abort_last got we=%0b ab=%0b done=%0b busy=%0b cnt=%0d lerr=%0b exp we=0 ab=1 done=0 busy=0 cnt=2 lerr=0",
               BUF_WE, ABORTED, DONE, BUSY, SAMPLE_COUNT, LOCK_ERR);
    end
    tick();
    total++;
    if ({ABORTED, DONE, BUF_WE} !== 3'b000) begin
      bad++;
      $display("FAIL abort_after got ab=%0b done=%0b we=%0b exp 0 0 0", ABORTED, DONE, BUF_WE);
    end
  endtask

  task automatic test_reset_mid();
    start_cap(4, 0, 1'b0, 0);
    settle();
    sample(10'd9);
    RESET_N = 1'b0;
    sample(10'd10);
    total++;
    if ({BUF_WE, BUF_ADDR, BUF_WDATA, BUSY, DONE, ABORTED, LOCK_ERR, SAMPLE_COUNT} !== '0) begin
      bad++;
      $display("FAIL reset_mid got we=%0b addr=%0d wd=%0d busy=%0b done=%0b ab=%0b lerr=%0b cnt=%0d exp all 0",
               BUF_WE, BUF_ADDR, BUF_WDATA, BUSY, DONE, ABORTED, LOCK_ERR, SAMPLE_COUNT);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_full_len();
    int errs = 0;
    start_cap(1024, 0, 1'b0, 0);
    settle();
    for (int i = 0; i < 1024; i++) begin
      sample(10'(i ^ 10'h155));
      if (BUF_WE !== 1'b1 || BUF_ADDR !== 10'(i) || BUF_WDATA !== 10'(i ^ 10'h155) || DONE !== (i == 1023)) begin
        errs++;
        if (errs <= 4)
          $display("FAIL full_w%0d got we=%0b addr=%0d wd=%0h done=%0b exp we=1 addr=%0d wd=%0h done=%0b",
                   i, BUF_WE, BUF_ADDR, BUF_WDATA, DONE, i, 10'(i ^ 10'h155), (i == 1023));
      end
    end
    total++;
    if (errs != 0) bad++;
    sample(10'd1);
    total++;
    if ({BUF_WE, BUSY, SAMPLE_COUNT} !== {1'b0, 1'b0, 11'd1024}) begin
      bad++;
      $display("FAIL full_end got we=%0b busy=%0b cnt=%0d exp we=0 busy=0 cnt=1024", BUF_WE, BUSY, SAMPLE_COUNT);
    end
  endtask

  initial begin
    RESET_N = 1'b0; CFG_START = 1'b0; CFG_ABORT = 1'b0; CFG_LEN = '0; CFG_DECIM = '0;
    CFG_TRIG_EN = 1'b0; CFG_TRIG_LEVEL = '0; ADC_LOCKED = 1'b1; APP_DATA = '0; APP_DATA_VALID = 1'b0;
    test_reset();
    test_basic();
    test_decim();
    test_trigger();
    test_settle_restart();
    test_lock_loss();
    test_abort();
    test_reset_mid();
    test_full_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
